// File: rtl/snake_game_ctrl_if.sv
// Snake game controller bus.
//  master : player/board side, drives start and buttons, observes game state
//  slave  : game controller, drives head/apple cells, score and status flags
//  start    level, starts a game from IDLE or DONE
//  buttons  {up,down,left,right}, active-high, debounced
//  position head cell {row[1:0],col[1:0]}
//  apple    apple cell, same encoding
//  score    apples eaten
//  eaten    one-cycle pulse per eat
//  running  game in progress (RUN or RESPAWN)
//  done     game finished
interface snake_game_ctrl_if #(
    parameter int SCORE_W = 4
);
    logic               start;
    logic [3:0]         buttons;
    logic [3:0]         position;
    logic [3:0]         apple;
    logic [SCORE_W-1:0] score;
    logic               eaten;
    logic               running;
    logic               done;

    modport master (
        output start, buttons,
        input  position, apple, score, eaten, running, done
    );

    modport slave (
        input  start, buttons,
        output position, apple, score, eaten, running, done
    );
endinterface

// File: rtl/snake_game_ctrl.sv
// Snake game logic feeding the 4x4 LED-matrix driver.
// Owns a single-cell snake head and an apple; moves the head one cell per
// MOVE_PERIOD clocks in the last-pressed direction with wrap-around, counts
// eaten apples and places each new apple from an 8-bit LFSR.
// Ports:
//  clock  system clock, rising edge
//  reset  synchronous, active-high
//  bus    snake_game_ctrl_if.slave (start/buttons in; position, apple,
//         score, eaten, running, done out -- all registered)
module snake_game_ctrl #(
    parameter int         MOVE_PERIOD = 25_000_000,
    parameter int         SCORE_W     = 4,
    parameter logic [3:0] START_POS   = 4'd0,
    parameter logic [3:0] START_APPLE = 4'd10,
    parameter logic [7:0] LFSR_SEED   = 8'hA5
) (
    input  logic                clock,
    input  logic                reset,
    snake_game_ctrl_if.slave    bus
);
    localparam int CW = (MOVE_PERIOD > 2) ? $clog2(MOVE_PERIOD) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(MOVE_PERIOD - 1);

    typedef enum logic [1:0] {IDLE, RUN, RESPAWN, DONE} state_t;
    typedef enum logic [1:0] {DIR_UP, DIR_DOWN, DIR_LEFT, DIR_RIGHT} dir_t;

    state_t             state;
    dir_t               dir;
    dir_t               btn_dir;
    logic               btn_any;
    logic [CW-1:0]      cnt;
    logic [7:0]         lfsr;
    logic [3:0]         position;
    logic [3:0]         apple;
    logic [SCORE_W-1:0] score;
    logic [SCORE_W-1:0] score_inc;
    logic               eaten;
    logic               running;
    logic               done;
    logic [1:0]         row_nxt;
    logic [1:0]         col_nxt;
    logic [3:0]         head_nxt;
    logic               lfsr_fb;

    // x^8+x^6+x^5+x^4+1; shifting left keeps any non-zero seed non-zero.
    assign lfsr_fb   = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];
    assign score_inc = score + 1'b1;

    // Button priority up > down > left > right.
    always_comb begin
        btn_any = |bus.buttons;
        btn_dir = DIR_RIGHT;
        if (bus.buttons[3])      btn_dir = DIR_UP;
        else if (bus.buttons[2]) btn_dir = DIR_DOWN;
        else if (bus.buttons[1]) btn_dir = DIR_LEFT;
    end

    // Next head cell; 2-bit row/col arithmetic gives the edge wrap for free.
    always_comb begin
        row_nxt = position[3:2];
        col_nxt = position[1:0];
        case (dir)
            DIR_UP:    row_nxt = position[3:2] - 2'd1;
            DIR_DOWN:  row_nxt = position[3:2] + 2'd1;
            DIR_LEFT:  col_nxt = position[1:0] - 2'd1;
            default:   col_nxt = position[1:0] + 2'd1;
        endcase
        head_nxt = {row_nxt, col_nxt};
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            dir      <= DIR_RIGHT;
            cnt      <= '0;
            lfsr     <= LFSR_SEED;
            position <= START_POS;
            apple    <= START_APPLE;
            score    <= '0;
            eaten    <= 1'b0;
            running  <= 1'b0;
            done     <= 1'b0;
        end else begin
            lfsr  <= {lfsr[6:0], lfsr_fb};
            eaten <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        state    <= RUN;
                        position <= START_POS;
                        apple    <= START_APPLE;
                        score    <= '0;
                        cnt      <= '0;
                        dir      <= DIR_RIGHT;
                        running  <= 1'b1;
                        done     <= 1'b0;
                    end
                end
                RUN: begin
                    // The move below uses the old dir, so a press on the
                    // move edge only steers the following move.
                    if (btn_any) dir <= btn_dir;
                    if (cnt == CNT_LAST) begin
                        cnt      <= '0;
                        position <= head_nxt;
                        if (head_nxt == apple) begin
                            score <= score_inc;
                            eaten <= 1'b1;
                            if (score_inc == '1) begin
                                state   <= DONE;
                                running <= 1'b0;
                                done    <= 1'b1;
                            end else begin
                                state <= RESPAWN;
                            end
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RESPAWN: begin
                    if (btn_any) dir <= btn_dir;
                    cnt <= '0;
                    // Retry until the candidate cell is off the head.
                    if (lfsr[3:0] != position) begin
                        apple <= lfsr[3:0];
                        state <= RUN;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.position = position;
    assign bus.apple    = apple;
    assign bus.score    = score;
    assign bus.eaten    = eaten;
    assign bus.running  = running;
    assign bus.done     = done;
endmodule

// File: tb/tb_snake_game_ctrl.sv
// Directed bench for snake_game_ctrl with MOVE_PERIOD=4.
// dut0 uses SCORE_W=4; dut1 uses SCORE_W=1 so a single apple ends the game.
module tb_snake_game_ctrl;
    logic clk = 1'b0;
    logic rst0, rst1;
    always #5 clk = ~clk;

    snake_game_ctrl_if #(.SCORE_W(4)) sif0 ();
    snake_game_ctrl_if #(.SCORE_W(1)) sif1 ();

    snake_game_ctrl #(.MOVE_PERIOD(4), .SCORE_W(4)) dut0 (
        .clock(clk), .reset(rst0), .bus(sif0.slave)
    );
    snake_game_ctrl #(.MOVE_PERIOD(4), .SCORE_W(1)) dut1 (
        .clock(clk), .reset(rst1), .bus(sif1.slave)
    );

    typedef struct {
        bit       sel;   // 0: dut0, 1: dut1
        bit       rst;
        bit       st;
        bit [3:0] btn;   // {up,down,left,right}
        int       cyc;   // clocks to hold these inputs
        int       pos;
        int       apl;
        int       scr;
        bit       run;
        bit       dn;
        bit       eat;
    } vec_t;

    vec_t vt[31];
    int   n_vec = 0;
    int   n_err = 0;

    function automatic vec_t mk(bit sel, bit rst, bit st, bit [3:0] btn, int cyc,
                                int pos, int apl, int scr, bit run, bit dn, bit eat);
        vec_t v;
        v.sel = sel; v.rst = rst; v.st = st; v.btn = btn; v.cyc = cyc;
        v.pos = pos; v.apl = apl; v.scr = scr; v.run = run; v.dn = dn; v.eat = eat;
        return v;
    endfunction

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input int idx, input string nm, input int act, input int exp);
        if (act != exp) begin
            n_err++;
            $display("FAIL vec%0d %s: got %0d, expected %0d", idx, nm, act, exp);
        end
    endtask

    task automatic run_vecs(input int lo, input int hi);
        for (int i = lo; i < hi; i++) begin
            vec_t v;
            int   pos, apl, scr, run, dn, eat;
            v = vt[i];
            rst0         = (v.sel == 1'b0) ? v.rst : 1'b0;
            rst1         = (v.sel == 1'b1) ? v.rst : 1'b0;
            sif0.start   = (v.sel == 1'b0) ? v.st  : 1'b0;
            sif1.start   = (v.sel == 1'b1) ? v.st  : 1'b0;
            sif0.buttons = (v.sel == 1'b0) ? v.btn : 4'd0;
            sif1.buttons = (v.sel == 1'b1) ? v.btn : 4'd0;
            step(v.cyc);
            if (v.sel == 1'b0) begin
                pos = int'(sif0.position); apl = int'(sif0.apple); scr = int'(sif0.score);
                run = int'(sif0.running);  dn  = int'(sif0.done);  eat = int'(sif0.eaten);
            end else begin
                pos = int'(sif1.position); apl = int'(sif1.apple); scr = int'(sif1.score);
                run = int'(sif1.running);  dn  = int'(sif1.done);  eat = int'(sif1.eaten);
            end
            n_vec++;
            chk(i, "position", pos, v.pos);
            if (v.apl >= 0) chk(i, "apple", apl, v.apl);
            chk(i, "score",   scr, v.scr);
            chk(i, "running", run, int'(v.run));
            chk(i, "done",    dn,  int'(v.dn));
            chk(i, "eaten",   eat, int'(v.eat));
        end
    endtask

    initial begin
        //            sel rst st btn     cyc pos apl scr run dn eat
        // reset, start, wrap along row 0
        vt[0]  = mk(0, 1, 0, 4'b0000, 1,  0, 10, 0, 0, 0, 0);
        vt[1]  = mk(0, 0, 1, 4'b0000, 1,  0, 10, 0, 1, 0, 0);
        vt[2]  = mk(0, 0, 0, 4'b0000, 4,  1, 10, 0, 1, 0, 0);
        vt[3]  = mk(0, 0, 0, 4'b0000, 4,  2, 10, 0, 1, 0, 0);
        vt[4]  = mk(0, 0, 0, 4'b0000, 4,  3, 10, 0, 1, 0, 0);
        vt[5]  = mk(0, 0, 0, 4'b0000, 3,  3, 10, 0, 1, 0, 0);
        vt[6]  = mk(0, 0, 0, 4'b0000, 1,  0, 10, 0, 1, 0, 0);
        // up+left -> up wins, wrap to row 3; then left wraps to col 3
        vt[7]  = mk(0, 0, 0, 4'b1010, 4, 12, 10, 0, 1, 0, 0);
        vt[8]  = mk(0, 0, 0, 4'b0010, 4, 15, 10, 0, 1, 0, 0);
        // reset, start, down 2, right 2 -> eat at cell 10
        vt[9]  = mk(0, 1, 0, 4'b0000, 1,  0, 10, 0, 0, 0, 0);
        vt[10] = mk(0, 0, 1, 4'b0000, 1,  0, 10, 0, 1, 0, 0);
        vt[11] = mk(0, 0, 0, 4'b0100, 4,  4, 10, 0, 1, 0, 0);
        vt[12] = mk(0, 0, 0, 4'b0100, 4,  8, 10, 0, 1, 0, 0);
        vt[13] = mk(0, 0, 0, 4'b0001, 4,  9, 10, 0, 1, 0, 0);
        vt[14] = mk(0, 0, 0, 4'b0000, 4, 10, 10, 1, 1, 0, 1);
        // reset after a scored game, idle without start
        vt[15] = mk(0, 1, 0, 4'b0000, 1,  0, 10, 0, 0, 0, 0);
        vt[16] = mk(0, 0, 0, 4'b0000, 20, 0, 10, 0, 0, 0, 0);
        // start pulse mid-period in RUN must not disturb the move phase
        vt[17] = mk(0, 0, 1, 4'b0000, 1,  0, 10, 0, 1, 0, 0);
        vt[18] = mk(0, 0, 0, 4'b0000, 2,  0, 10, 0, 1, 0, 0);
        vt[19] = mk(0, 0, 1, 4'b0000, 1,  0, 10, 0, 1, 0, 0);
        vt[20] = mk(0, 0, 0, 4'b0000, 1,  1, 10, 0, 1, 0, 0);
        vt[21] = mk(0, 0, 0, 4'b0000, 4,  2, 10, 0, 1, 0, 0);
        // SCORE_W=1: first eat ends the game, then restart
        vt[22] = mk(1, 1, 0, 4'b0000, 1,  0, 10, 0, 0, 0, 0);
        vt[23] = mk(1, 0, 1, 4'b0000, 1,  0, 10, 0, 1, 0, 0);
        vt[24] = mk(1, 0, 0, 4'b0100, 4,  4, 10, 0, 1, 0, 0);
        vt[25] = mk(1, 0, 0, 4'b0100, 4,  8, 10, 0, 1, 0, 0);
        vt[26] = mk(1, 0, 0, 4'b0001, 4,  9, 10, 0, 1, 0, 0);
        vt[27] = mk(1, 0, 0, 4'b0000, 4, 10, 10, 1, 0, 1, 1);
        vt[28] = mk(1, 0, 0, 4'b0001, 20, 10, 10, 1, 0, 1, 0);
        vt[29] = mk(1, 0, 1, 4'b0000, 1,  0, 10, 0, 1, 0, 0);
        vt[30] = mk(1, 0, 0, 4'b0000, 4,  1, 10, 0, 1, 0, 0);

        rst0 = 1'b1; rst1 = 1'b1;
        sif0.start = 1'b0; sif1.start = 1'b0;
        sif0.buttons = 4'd0; sif1.buttons = 4'd0;
        step(1);

        run_vecs(0, 15);

        // Respawn: eaten drops after one cycle, a new apple appears off the head.
        begin
            int k;
            step(1);
            n_vec++;
            chk(15, "eaten_pulse", int'(sif0.eaten), 0);
            k = 0;
            while (sif0.apple == 4'd10 && k < 256) begin
                step(1);
                k++;
            end
            n_vec++;
            if (sif0.apple == 4'd10) begin
                n_err++;
                $display("FAIL respawn_timeout: apple still %0d after %0d cycles, expected a new cell", sif0.apple, k);
            end
            if (sif0.apple == sif0.position) begin
                n_err++;
                $display("FAIL respawn_on_head: apple %0d, position %0d, expected them to differ", sif0.apple, sif0.position);
            end
            chk(15, "respawn_pos",   int'(sif0.position), 10);
            chk(15, "respawn_score", int'(sif0.score), 1);
            chk(15, "respawn_run",   int'(sif0.running), 1);
        end

        run_vecs(15, 31);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
